// File: rtl/instr_fetch_unit_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instr_fetch_unit_pkg : fetch-unit state encoding and opcode field layout
// rev 1.0
// ---------------------------------------------------------------------------
package instr_fetch_unit_pkg;

   typedef enum logic [1:0] {
      S_REQ    = 2'd0,
      S_OUT    = 2'd1,
      S_HALTED = 2'd2
   } fetch_state_t;

   localparam logic [5:0]  C_HALT_OP    = 6'b111111;
   localparam logic [31:0] C_PC_STEP    = 32'd4;
   localparam int          C_OPCODE_MSB = 31;
   localparam int          C_OPCODE_LSB = 26;

   function automatic logic [5:0] get_opcode(input logic [31:0] word);
      return word[C_OPCODE_MSB:C_OPCODE_LSB];
   endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instr_fetch_unit : PC owner, imem req/ack fetch, valid/ready issue to decode
// rev 1.0
// ---------------------------------------------------------------------------
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = C_PC_STEP,
   parameter logic [5:0]  HALT_OP  = C_HALT_OP
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic [31:0] instr_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        halted,
   output logic [15:0] retired_cnt
);

   fetch_state_t r_state, w_state_nxt;
   logic [31:0]  r_pc, w_pc_nxt;
   logic         r_kill, w_kill_nxt;
   logic [31:0]  r_target, w_target_nxt;
   logic [31:0]  r_instr;
   logic [31:0]  r_instr_pc;
   logic [15:0]  r_retired_cnt;
   logic         w_capture;
   logic         w_retire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_REQ;
         r_pc          <= RESET_PC;
         r_kill        <= 1'b0;
         r_target      <= '0;
         r_instr       <= '0;
         r_instr_pc    <= '0;
         r_retired_cnt <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_pc     <= w_pc_nxt;
         r_kill   <= w_kill_nxt;
         r_target <= w_target_nxt;
         if (w_capture) begin
            r_instr    <= imem_rdata;
            r_instr_pc <= r_pc;
         end
         if (w_retire) begin
            r_retired_cnt <= r_retired_cnt + 16'd1;
         end
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_pc_nxt     = r_pc;
      w_kill_nxt   = r_kill;
      w_target_nxt = r_target;
      w_capture    = 1'b0;
      w_retire     = 1'b0;
      case (r_state)
         S_REQ: begin
            if (imem_ack) begin
               if (redirect_valid) begin
                  w_pc_nxt   = redirect_pc;
                  w_kill_nxt = 1'b0;
               end else if (r_kill) begin
                  // Data for the stale address is dropped; resume at the saved target.
                  w_pc_nxt   = r_target;
                  w_kill_nxt = 1'b0;
               end else begin
                  w_capture   = 1'b1;
                  w_state_nxt = S_OUT;
               end
            end else if (redirect_valid) begin
               // imem_addr must stay stable until ack, so the redirect is parked.
               w_target_nxt = redirect_pc;
               w_kill_nxt   = 1'b1;
            end
         end
         S_OUT: begin
            w_retire = instr_ready;
            if (instr_ready && (get_opcode(r_instr) == HALT_OP)) begin
               w_state_nxt = S_HALTED;
            end else if (redirect_valid) begin
               w_pc_nxt    = redirect_pc;
               w_state_nxt = S_REQ;
            end else if (instr_ready) begin
               w_pc_nxt    = r_pc + PC_STEP;
               w_state_nxt = S_REQ;
            end
         end
         S_HALTED: begin
            w_state_nxt = S_HALTED;
         end
         default: begin
            w_state_nxt = S_REQ;
         end
      endcase
   end

   assign imem_req    = rst_n && (r_state == S_REQ);
   assign imem_addr   = r_pc;
   assign instr_valid = (r_state == S_OUT);
   assign halted      = (r_state == S_HALTED);
   assign instr       = r_instr;
   assign opcode      = get_opcode(r_instr);
   assign instr_pc    = r_instr_pc;
   assign retired_cnt = r_retired_cnt;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit : scoreboard bench for instr_fetch_unit
// rev 1.0
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

   typedef struct {
      logic [31:0] word;
      logic [31:0] pc;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [31:0] instr_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halted;
   logic [15:0] retired_cnt;

   exp_t        r_sb_q[$];
   int          r_n_cmp;
   int          r_n_err;
   logic [15:0] r_model_cnt;

   instr_fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .opcode         (opcode),
      .instr_pc       (instr_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halted         (halted),
      .retired_cnt    (retired_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      r_n_cmp++;
      if (obs !== exp) begin
         r_n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Answers the pending request after lat wait cycles; keep=0 means the DUT must drop it.
   task automatic mem_ack(input int lat, input logic [31:0] exp_addr,
                          input logic [31:0] word, input bit keep);
      logic [31:0] a;
      int          n;
      exp_t        e;
      n = 0;
      while (!imem_req && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!imem_req) begin
         chk("req_timeout", 32'(imem_req), 32'd1);
         return;
      end
      a = imem_addr;
      chk("fetch_addr", a, exp_addr);
      for (int i = 0; i < lat; i++) begin
         @(negedge clk);
         chk("addr_stable", imem_addr, a);
         chk("wait_no_valid", 32'(instr_valid), 32'd0);
      end
      imem_ack   = 1'b1;
      imem_rdata = word;
      if (keep) begin
         e.word = word;
         e.pc   = a;
         r_sb_q.push_back(e);
      end
      @(negedge clk);
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (!instr_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("valid_timeout", 32'(instr_valid), 32'd1);
   endtask

   task automatic pop_cmp();
      exp_t e;
      if (r_sb_q.size() == 0) begin
         chk("sb_empty", 32'd0, 32'd1);
         return;
      end
      e = r_sb_q.pop_front();
      chk("instr", instr, e.word);
      chk("instr_pc", instr_pc, e.pc);
      chk("opcode", 32'(opcode), 32'(e.word[31:26]));
   endtask

   task automatic accept(input int hold);
      logic [31:0] held;
      wait_valid();
      held = instr;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", 32'(instr_valid), 32'd1);
         chk("hold_instr", instr, held);
      end
      pop_cmp();
      instr_ready = 1'b1;
      @(negedge clk);
      instr_ready = 1'b0;
      r_model_cnt++;
      chk("retired_cnt", 32'(retired_cnt), 32'(r_model_cnt));
   endtask

   initial begin
      r_n_cmp = 0;
      r_n_err = 0;
      r_model_cnt = '0;
      rst_n = 1'b0;
      imem_ack = 1'b0;
      imem_rdata = '0;
      instr_ready = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = '0;

      repeat (2) @(negedge clk);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_cnt", 32'(retired_cnt), 32'd0);
      chk("rst_instr", instr, 32'd0);
      rst_n = 1'b1;
      #1;
      chk("post_rst_req", 32'(imem_req), 32'd1);
      chk("post_rst_addr", imem_addr, 32'h0);

      // zero-wait memory
      mem_ack(0, 32'h0, 32'h2001_0005, 1'b1);
      chk("zw_valid", 32'(instr_valid), 32'd1);
      chk("zw_opcode", 32'(opcode), 32'h08);
      accept(0);
      chk("seq_addr", imem_addr, 32'h4);

      // 3-cycle memory, decode stalls 4 cycles
      mem_ack(3, 32'h4, 32'h1234_5678, 1'b1);
      chk("slow_valid", 32'(instr_valid), 32'd1);
      accept(4);

      // redirect parked in REQ, first ack dropped
      @(negedge clk);
      chk("rd_req", 32'(imem_req), 32'd1);
      redirect_valid = 1'b1;
      redirect_pc = 32'h40;
      @(negedge clk);
      redirect_valid = 1'b0;
      chk("rd_addr_held", imem_addr, 32'h8);
      imem_ack = 1'b1;
      imem_rdata = 32'hAAAA_0001;
      @(negedge clk);
      imem_ack = 1'b0;
      chk("rd_dropped", 32'(instr_valid), 32'd0);
      chk("rd_new_addr", imem_addr, 32'h40);
      mem_ack(1, 32'h40, 32'h8C00_0040, 1'b1);
      accept(0);

      // ack and redirect together in REQ
      imem_ack = 1'b1;
      imem_rdata = 32'hBBBB_0002;
      redirect_valid = 1'b1;
      redirect_pc = 32'h80;
      @(negedge clk);
      imem_ack = 1'b0;
      redirect_valid = 1'b0;
      chk("ackrd_dropped", 32'(instr_valid), 32'd0);
      chk("ackrd_addr", imem_addr, 32'h80);

      // ready + redirect in OUT: counted, redirect wins
      mem_ack(0, 32'h80, 32'h1000_0010, 1'b1);
      wait_valid();
      pop_cmp();
      instr_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'h100;
      @(negedge clk);
      instr_ready = 1'b0;
      redirect_valid = 1'b0;
      r_model_cnt++;
      chk("br_cnt", 32'(retired_cnt), 32'(r_model_cnt));
      chk("br_addr", imem_addr, 32'h100);
      chk("br_req", 32'(imem_req), 32'd1);

      // redirect in OUT without ready: not counted
      mem_ack(0, 32'h100, 32'h0400_0001, 1'b1);
      wait_valid();
      void'(r_sb_q.pop_front());
      redirect_valid = 1'b1;
      redirect_pc = 32'h200;
      @(negedge clk);
      redirect_valid = 1'b0;
      chk("flush_cnt", 32'(retired_cnt), 32'(r_model_cnt));
      chk("flush_addr", imem_addr, 32'h200);

      // counter wrap
      force dut.r_retired_cnt = 16'hFFFF;
      @(negedge clk);
      release dut.r_retired_cnt;
      r_model_cnt = 16'hFFFF;
      chk("preload_cnt", 32'(retired_cnt), 32'hFFFF);
      mem_ack(0, 32'h200, 32'h0000_0000, 1'b1);
      accept(0);
      chk("wrap_cnt", 32'(retired_cnt), 32'd0);

      // halt
      mem_ack(2, 32'h204, 32'hFC00_0000, 1'b1);
      accept(0);
      chk("halted", 32'(halted), 32'd1);
      chk("halt_req", 32'(imem_req), 32'd0);
      chk("halt_valid", 32'(instr_valid), 32'd0);
      for (int i = 0; i < 3; i++) begin
         redirect_valid = 1'b1;
         redirect_pc = 32'h300;
         imem_ack = 1'b1;
         instr_ready = 1'b1;
         @(negedge clk);
         chk("halt_stuck", 32'(halted), 32'd1);
         chk("halt_no_req", 32'(imem_req), 32'd0);
      end
      redirect_valid = 1'b0;
      imem_ack = 1'b0;
      instr_ready = 1'b0;
      chk("halt_cnt", 32'(retired_cnt), 32'(r_model_cnt));
      #2 rst_n = 1'b0;
      #1;
      chk("halt_rst", 32'(halted), 32'd0);
      chk("halt_rst_cnt", 32'(retired_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      r_model_cnt = '0;

      // async reset while waiting for ack
      @(negedge clk);
      chk("mid_req", 32'(imem_req), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_req_drop", 32'(imem_req), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("mid_addr", imem_addr, 32'h0);
      chk("mid_req_back", 32'(imem_req), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", r_n_cmp, r_n_err);
      $finish;
   end

endmodule
`default_nettype wire
